// File: rtl/decod_seq_pkg.sv
// decod_seq_pkg: shared definitions for the decoder select sequencer.
//   state_t  - FSM encoding (IDLE=0, RUN=1)
//   SEL_W    - width of the select code
//   SEL_MAX  - highest select code (wrap point when counting up)
//   sel_next - next select code in the chosen direction, modulo 2^SEL_W
package decod_seq_pkg;

    localparam int SEL_W = 3;
    localparam logic [SEL_W-1:0] SEL_MAX = 3'd7;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic [SEL_W-1:0] sel_next(input logic [SEL_W-1:0] s,
                                                  input logic down);
        return down ? (s - SEL_W'(1)) : (s + SEL_W'(1));
    endfunction

endpackage

// File: rtl/decod_seq_prescaler.sv
// decod_seq_prescaler: step-rate counter for decod_sel_seq.
// Counts 0..PRESCALE-1 while cnt_en=1 and wraps to 0 after the terminal count.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - synchronous clear to 0 (wins over cnt_en)
//   cnt_en     - count enable
//   tc         - terminal count, high while the counter sits at PRESCALE-1
module decod_seq_prescaler #(
    parameter int PRESCALE = 50000,
    parameter int PS_W     = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic cnt_en,
    output logic tc
);

    localparam logic [PS_W-1:0] TC_VAL = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] cnt;

    assign tc = (cnt == TC_VAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (cnt_en) begin
            // Wrapping on tc keeps the count within 0..PRESCALE-1.
            cnt <= tc ? '0 : cnt + PS_W'(1);
        end
    end

endmodule

// File: rtl/decod_sel_seq.sv
// decod_sel_seq: select-code sequencer feeding a 3-to-8 decoder.
// Steps sel through 0..7 every PRESCALE cycles while enabled, with a
// synchronous load that overrides stepping. step/wrap are registered pulses
// coincident with the new sel value.
// Optional feature: define DECOD_SEQ_DIR_EN to add the dir port (1 = count down).
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   en         - run enable (level)
//   load       - load strobe, load_val -> sel
//   load_val   - code to load
//   dir        - count direction (only with DECOD_SEQ_DIR_EN)
//   sel        - registered select code
//   step       - pulse: sel shows a new value this cycle
//   wrap       - pulse: sel shows a wrapped value this cycle
module decod_sel_seq
    import decod_seq_pkg::*;
#(
    parameter int PRESCALE = 50000,
    parameter int PS_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [SEL_W-1:0] load_val,
`ifdef DECOD_SEQ_DIR_EN
    input  logic             dir,
`endif
    output logic [SEL_W-1:0] sel,
    output logic             step,
    output logic             wrap
);

    state_t state, state_nxt;
    logic   ps_clr;
    logic   ps_tc;
    logic   do_step;
    logic   down;
    logic   wrap_hit;

`ifdef DECOD_SEQ_DIR_EN
    assign down = dir;
`else
    assign down = 1'b0;
`endif

    // Wrap is judged on the code being left, in the direction being taken.
    assign wrap_hit = down ? (sel == '0) : (sel == SEL_MAX);

    decod_seq_prescaler #(
        .PRESCALE (PRESCALE),
        .PS_W     (PS_W)
    ) u_ps (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (ps_clr),
        .cnt_en (state == RUN),
        .tc     (ps_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Only a RUN cycle with en held and no load lets the prescaler advance;
    // every other case (idle, leaving RUN, load) restarts the step interval.
    always_comb begin
        state_nxt = state;
        ps_clr    = 1'b1;
        do_step   = 1'b0;
        case (state)
            IDLE: begin
                if (en) state_nxt = RUN;
            end
            RUN: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else if (!load) begin
                    ps_clr  = 1'b0;
                    do_step = ps_tc;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel  <= '0;
            step <= 1'b0;
            wrap <= 1'b0;
        end else begin
            step <= 1'b0;
            wrap <= 1'b0;
            if (load) begin
                // A load always counts as a new code, even if unchanged.
                sel  <= load_val;
                step <= 1'b1;
            end else if (do_step) begin
                sel  <= sel_next(sel, down);
                step <= 1'b1;
                wrap <= wrap_hit;
            end
        end
    end

endmodule

// File: doc/decod_sel_seq.md
# decod_sel_seq

Upstream select sequencer for the 3-to-8 decoder: generates the 3-bit select code `sel` that drives the decoder's `i` input. It steps `sel` through 0..7 at a programmable rate, supports a synchronous load of an arbitrary code, and flags each step and each wrap-around. Typical use is channel/LED scanning, with the decoder's one-hot output selecting the active channel.

## Interface
Parameters:
- `PRESCALE`, default 50000: `clk` cycles per `sel` step; legal range 1..65535.
- `PS_W`, default 16: prescaler counter width; must satisfy 2^PS_W >= PRESCALE.

Ports:
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: run enable; level-sensitive.
- `load` in 1: synchronous load strobe.
- `load_val` in 3: code loaded into `sel` when `load`=1.
- `dir` in 1: count direction, 0=up, 1=down; present only with `DECOD_SEQ_DIR_EN`.
- `sel` out 3: select code to the decoder; registered.
- `step` out 1: one-cycle pulse, high in the cycle `sel` first shows a new value.
- `wrap` out 1: one-cycle pulse, high in the cycle `sel` first shows a wrapped value.

## Operation
- States: IDLE, RUN.
- Reset (asynchronous, while `rst_n`=0):
  - state=IDLE, prescaler=0, `sel`=3'd0, `step`=0, `wrap`=0.
- IDLE:
  - prescaler held at 0; `sel` holds its value.
  - `en`=1 at an edge -> RUN.
- RUN:
  - Prescaler increments every cycle.
  - On the edge where prescaler==PRESCALE-1: prescaler<=0, `sel`<=`sel`+1 modulo 8, `step`<=1.
  - `wrap`<=1 on the 7->0 transition.
  - `en`=0 at an edge -> IDLE: prescaler cleared, `sel` holds, no step on that edge.
- `load`=1 has priority over everything except reset, in either state:
  - `sel`<=`load_val`, prescaler<=0, `step`<=1, `wrap`<=0.
  - State follows `en` as usual.
  - `load_val` equal to the current `sel` still pulses `step`.
- Simultaneous `load` and step terminal count: the load wins and no increment occurs.
- `step` and `wrap` are cleared on every edge where they are not set.
- Arithmetic: `sel` is 3-bit unsigned with natural wrap. The prescaler never exceeds PRESCALE-1.

## Timing
- `en` first sampled high at edge k: RUN from k; first step at edge k+PRESCALE, then every PRESCALE cycles.
- PRESCALE=1: `sel` advances on every edge in RUN; `step` stays high continuously.
- Load latency: 1 edge. `sel` shows `load_val` in the cycle after the edge where `load` is sampled.
- `step` and `wrap` are coincident with the new `sel` value, so a downstream decoder sees a stable code for the whole `step` cycle.
- Reset mid-run: outputs go to reset values immediately (asynchronous). Release is synchronous to the next edge; the first step occurs PRESCALE cycles after `en` is sampled high following release.

## Configuration
- `DECOD_SEQ_DIR_EN` defined:
  - Adds the `dir` port.
  - `dir`=1 decrements `sel` modulo 8, with `wrap` on 0->7.
  - `dir` is sampled at each step edge; a change between steps never resets the prescaler.
- Not defined:
  - No `dir` port; up-count only; `wrap` only on 7->0.

## Structure
- Package `decod_seq_pkg`:
  - State encoding (IDLE=0, RUN=1).
  - `SEL_W`=3, `SEL_MAX`=3'd7.
- Sub-module `decod_seq_prescaler`:
  - Holds the PS_W-bit counter, with `clr` and `cnt_en` inputs and a terminal-count output `tc`.
- The top level holds the FSM, the `sel` register and the pulse outputs.

## Test plan
- Reset release, `en`=0 for 20 cycles -> `sel`=0, `step`=0, `wrap`=0 throughout.
- PRESCALE=4, `en`=1 held -> `sel` 0,1,2,… changing every 4 cycles; `step` is a 1-cycle pulse each change; `wrap` pulses exactly once, on the 7->0 edge.
- PRESCALE=4, `load`=1 with `load_val`=3'd6 mid-count -> `sel`=6 next cycle with `step`=1; next increment to 7 exactly 4 cycles later; then 7->0 with `wrap`=1.
- `en` dropped to 0 with `sel`=5 and prescaler=2 -> `sel` holds 5. `en` reasserted -> next step to 6 occurs a full 4 cycles after re-entering RUN.
- `rst_n` asserted asynchronously between edges with `sel`=3 -> `sel`=0 immediately with no clock edge.
- `DECOD_SEQ_DIR_EN`, PRESCALE=1, `dir`=1 from `sel`=1 -> 1,0,7,6 on successive edges; `wrap`=1 only on the 0->7 edge.
